// File: rtl/wave_capture_ctrl_pkg.sv
// Shared definitions for the waveform capture controller and the other writers of the sample RAM.
// Covers state encodings, buffer geometry and RAM address width.
package wave_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } cap_state_e;

  localparam int SAMPLES_PER_BUFFER = 256;
  localparam int RAM_AW             = 9;
  localparam int COL_W              = RAM_AW - 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SAMPLES_PER_BUFFER - 1);

endpackage

// File: rtl/wave_sample_fmt.sv
// Converts a signed audio sample to a display byte: inverted offset-binary top byte,
// so that positive swings plot upward (+max -> 8'h00, 0 -> 8'h7F, -min -> 8'hFF).
module wave_sample_fmt
  import wave_capture_ctrl_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [COL_W-1:0]    byte_o
);

  assign byte_o = {sample_i[SAMPLE_W-1], ~sample_i[SAMPLE_W-2:SAMPLE_W-8]};

  // Low-order bits are below display resolution.
  logic unused_lsbs;
  assign unused_lsbs = ^sample_i[SAMPLE_W-9:0];

endmodule

// File: rtl/wave_capture_ctrl.sv
// Fills the back half of the double-buffered 512x8 sample RAM from a rising zero crossing
// and swaps halves on a frame boundary. Optional free-run timeout: WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture_ctrl
  import wave_capture_ctrl_pkg::*;
#(
  parameter int SAMPLE_W        = 16,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                frame_done,
  output logic                write_enable,
  output logic [RAM_AW-1:0]   write_address,
  output logic [COL_W-1:0]    write_sample,
  output logic                read_index,
  output logic [1:0]          capture_state
);

  if (SAMPLE_W < 9) begin : g_bad_sample_w
    $error("wave_capture_ctrl: SAMPLE_W must be at least 9");
  end
  if (TIMEOUT_SAMPLES < 1) begin : g_bad_timeout
    $error("wave_capture_ctrl: TIMEOUT_SAMPLES must be at least 1");
  end

  cap_state_e        state_q, state_d;
  logic [COL_W-1:0]  count_q, count_d;
  logic              ri_q, ri_d;
  logic              prev_neg_q, prev_neg_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  data_q, data_d;

  logic              trigger;
  logic              wr_go;
  logic [COL_W-1:0]  wr_col;
  logic [COL_W-1:0]  fmt_byte;

  wave_sample_fmt #(
    .SAMPLE_W (SAMPLE_W)
  ) u_fmt (
    .sample_i (sample_in),
    .byte_o   (fmt_byte)
  );

  assign trigger = sample_valid & prev_neg_q & ~sample_in[SAMPLE_W-1];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_SAMPLES);

  logic [TO_W-1:0] to_q, to_d;
  logic            to_fire;

  // Forced capture once TIMEOUT_SAMPLES samples went by without a trigger.
  assign to_fire = sample_valid & ~trigger & (to_q == TO_LIMIT);

  always_comb begin
    to_d = '0;
    if (state_q == ST_ARMED && sample_valid && !trigger && !to_fire) begin
      to_d = to_q + TO_W'(1);
    end else if (state_q == ST_ARMED && !sample_valid) begin
      to_d = to_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  logic to_fire;
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ri_d       = ri_q;
    prev_neg_d = sample_valid ? sample_in[SAMPLE_W-1] : prev_neg_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_go      = 1'b0;
    wr_col     = count_q;

    case (state_q)
      ST_ARMED: begin
        if (trigger || to_fire) begin
          wr_go   = 1'b1;
          wr_col  = '0;
          count_d = COL_W'(1);
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (sample_valid) begin
          wr_go   = 1'b1;
          wr_col  = count_q;
          count_d = count_q + COL_W'(1);
          if (count_q == LAST_COL) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (frame_done) begin
          ri_d    = ~ri_q;
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase

    if (wr_go) begin
      we_d   = 1'b1;
      addr_d = {~ri_q, wr_col};
      data_d = fmt_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      count_q    <= '0;
      ri_q       <= 1'b0;
      prev_neg_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 9'h100;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ri_q       <= ri_d;
      prev_neg_q <= prev_neg_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_sample  = data_q;
  assign read_index    = ri_q;
  assign capture_state = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: expected RAM writes are queued as samples are driven
// and matched against write_enable pulses.
module tb_wave_capture_ctrl;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        frame_done;
  logic        write_enable;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;
  logic [1:0]  capture_state;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  fail_cnt = 0;

  wave_capture_ctrl #(
    .SAMPLE_W        (16),
    .TIMEOUT_SAMPLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .frame_done    (frame_done),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_sample  (write_sample),
    .read_index    (read_index),
    .capture_state (capture_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fmt(input logic [15:0] s);
    return {s[15], ~s[14:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] s, input logic fd, input logic expect_wr,
                       input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = s;
    frame_done   = fd;
    if (expect_wr) exp_q.push_back('{addr: a, data: d});
    @(negedge clk);
    sample_valid = 1'b0;
    frame_done   = 1'b0;
  endtask

  task automatic pulse_fd();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Every write pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (!reset && write_enable) begin
      total_cnt++;
      assert (exp_q.size() != 0) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h, expected no write",
               write_address, write_sample);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(write_address), 32'(mon_e.addr));
        chk("wr_data", 32'(write_sample), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] s;
    logic [7:0]  d;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    frame_done   = 1'b0;
    #3;
    chk("rst_we",    32'(write_enable),  32'h0);
    chk("rst_addr",  32'(write_address), 32'h100);
    chk("rst_data",  32'(write_sample),  32'h0);
    chk("rst_ri",    32'(read_index),    32'h0);
    chk("rst_state", 32'(capture_state), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // First capture into half 1: trigger on -5 -> +3, ramp fills the rest.
    drive(16'hFFFB, 1'b0, 1'b0, 9'h0, 8'h0);
    drive(16'd3, 1'b0, 1'b1, 9'h100, 8'h7F);
    chk("cap1_state_active", 32'(capture_state), 32'h1);
    for (int k = 1; k < 256; k++) begin
      s = 16'(k * 128);
      drive(s, 1'b0, 1'b1, 9'(9'h100 + k), fmt(s));
    end
    chk("cap1_state_wait", 32'(capture_state), 32'h2);
    chk("cap1_ri", 32'(read_index), 32'h0);
    chk("cap1_q_empty", 32'(exp_q.size()), 32'h0);

    // WAIT ignores samples, even ones that would be rising crossings.
    for (int k = 0; k < 10; k++) drive((k % 2 == 0) ? 16'hFFFF : 16'h0001, 1'b0, 1'b0, 9'h0, 8'h0);
    chk("wait_state", 32'(capture_state), 32'h2);
    pulse_fd();
    chk("swap1_ri", 32'(read_index), 32'h1);
    chk("swap1_state", 32'(capture_state), 32'h0);

    // No rising crossing until the final 0; writes go to half 0.
    drive(16'd3, 1'b0, 1'b0, 9'h0, 8'h0);
    drive(16'd4, 1'b0, 1'b0, 9'h0, 8'h0);
    drive(16'hFFFE, 1'b0, 1'b0, 9'h0, 8'h0);
    drive(16'hFFFF, 1'b0, 1'b0, 9'h0, 8'h0);
    chk("nocross_state", 32'(capture_state), 32'h0);
    drive(16'd0, 1'b0, 1'b1, 9'h000, 8'h7F);
    for (int k = 1; k < 100; k++) begin
      s = 16'(k * 300);
      drive(s, 1'b0, 1'b1, 9'(k), fmt(s));
    end
    chk("mid_state", 32'(capture_state), 32'h1);
    chk("mid_q_empty", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset at count=100, away from any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we",    32'(write_enable),  32'h0);
    chk("arst_addr",  32'(write_address), 32'h100);
    chk("arst_data",  32'(write_sample),  32'h0);
    chk("arst_ri",    32'(read_index),    32'h0);
    chk("arst_state", 32'(capture_state), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Capture with frame_done during ACTIVE, extreme samples, then swap with a coincident sample.
    drive(16'hFFFF, 1'b0, 1'b0, 9'h0, 8'h0);
    drive(16'd0, 1'b0, 1'b1, 9'h100, 8'h7F);
    for (int k = 1; k < 256; k++) begin
      s = 16'($urandom);
      d = fmt(s);
      if (k == 100) begin s = 16'h7FFF; d = 8'h00; end
      if (k == 200) begin s = 16'h8000; d = 8'hFF; end
      drive(s, (k == 50), 1'b1, 9'(9'h100 + k), d);
      if (k == 50) begin
        chk("fd_active_ri", 32'(read_index), 32'h0);
        chk("fd_active_state", 32'(capture_state), 32'h1);
      end
    end
    chk("cap2_state_wait", 32'(capture_state), 32'h2);
    chk("cap2_ri", 32'(read_index), 32'h0);
    drive(16'hFFFD, 1'b1, 1'b0, 9'h0, 8'h0);
    chk("swap2_ri", 32'(read_index), 32'h1);
    chk("swap2_state", 32'(capture_state), 32'h0);
    drive(16'd5, 1'b0, 1'b1, 9'h000, 8'h7F);
    chk("retrig_state", 32'(capture_state), 32'h1);
    chk("retrig_q_empty", 32'(exp_q.size()), 32'h0);

    // Constant positive input: only the timeout can start a capture.
    do_reset();
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      drive(16'd7, 1'b0, (k >= 5), 9'(9'h100 + ((k >= 5) ? (k - 5) : 0)), 8'h7F);
      if (k == 4) chk("to_before_state", 32'(capture_state), 32'h0);
    end
    chk("to_after_state", 32'(capture_state), 32'h1);
`else
    for (int k = 1; k <= 8; k++) drive(16'd7, 1'b0, 1'b0, 9'h0, 8'h0);
    chk("noto_state", 32'(capture_state), 32'h0);
`endif
    @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
